// File: rtl/pam4_tx_mapper_pkg.sv
// Shared constants and level arithmetic for the PAM4 TX mapper.
// The level map is Gray when PAM4_GRAY_EN is defined and natural binary otherwise.
package pam4_tx_mapper_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int level_width(input int pr_len, input int res);
        return pr_len * res;
    endfunction

    // Signed level for one 2-bit symbol; the caller truncates to its level width.
    function automatic logic signed [31:0] pam4_level(input logic [1:0] sym, input int s);
        logic [1:0]         rank;
        logic signed [31:0] lvl;
`ifdef PAM4_GRAY_EN
        rank = {sym[1], sym[1] ^ sym[0]};
`else
        rank = sym;
`endif
        case (rank)
            2'd0:    lvl = -((32'sd3 * s) / 32'sd2);
            2'd1:    lvl = -(s / 32'sd2);
            2'd2:    lvl = s / 32'sd2;
            2'd3:    lvl = (32'sd3 * s) / 32'sd2;
            default: lvl = 32'sd0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/pam4_tx_mapper_if.sv
// Word input and level output handshakes of the PAM4 TX mapper.
interface pam4_tx_mapper_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LEVEL_W    = 16
);
    logic [DATA_WIDTH-1:0]     in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [LEVEL_W-1:0] out_level;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_level, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_level, out_valid
    );
endinterface

// File: rtl/pam4_tx_mapper_level_lut.sv
// Combinational 2-bit symbol to signed PAM4 level lookup.
module pam4_level_lut
    import pam4_tx_mapper_pkg::*;
#(
    parameter int SYMBOL_SEPERATION = 56,
    parameter int LEVEL_W           = 16
) (
    input  logic [1:0]                sym_i,
    output logic signed [LEVEL_W-1:0] level_o
);
    logic signed [31:0] level_full_s;

    always_comb begin
        level_full_s = pam4_level(sym_i, SYMBOL_SEPERATION);
        level_o      = level_full_s[LEVEL_W-1:0];
    end
endmodule

// File: rtl/pam4_tx_mapper.sv
// PAM4 TX mapper: splits words into 2-bit symbols (MSB pair first), one level per cycle.
// Build option PAM4_GRAY_EN selects the Gray level map instead of natural binary.
module pam4_tx_mapper
    import pam4_tx_mapper_pkg::*;
#(
    parameter int PULSE_RESPONSE_LENGTH = 2,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int DATA_WIDTH            = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pam4_tx_mapper_if.slave   bus,
    output logic [31:0]       sym_count_o
);
    localparam int LEVEL_W = level_width(PULSE_RESPONSE_LENGTH, SIGNAL_RESOLUTION);
    localparam int NSYM    = DATA_WIDTH / 2;
    localparam int IDX_W   = (NSYM > 1) ? $clog2(NSYM) : 1;

    logic [0:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic signed [LEVEL_W-1:0] level_q, level_d;
    logic                      valid_q, valid_d;
    logic [31:0]               count_q, count_d;

    logic                      last_s;
    logic                      xfer_s;
    logic                      in_ready_s;
    logic                      accept_s;
    logic [DATA_WIDTH-1:0]     shifted_s;
    logic [1:0]                next_sym_s;
    logic signed [LEVEL_W-1:0] next_level_s;

    assign last_s     = (idx_q == IDX_W'(NSYM - 1));
    assign xfer_s     = valid_q & bus.out_ready;
    assign in_ready_s = ~rst_i & ((state_q == ST_IDLE) |
                                  ((state_q == ST_SHIFT) & last_s & bus.out_ready));
    assign accept_s   = bus.in_valid & in_ready_s;
    assign shifted_s  = shreg_q << 2;
    // A freshly accepted word always takes priority over the shifted remainder.
    assign next_sym_s = accept_s ? bus.in_data[DATA_WIDTH-1 -: 2] : shifted_s[DATA_WIDTH-1 -: 2];

    pam4_level_lut #(
        .SYMBOL_SEPERATION (SYMBOL_SEPERATION),
        .LEVEL_W           (LEVEL_W)
    ) u_lut (
        .sym_i   (next_sym_s),
        .level_o (next_level_s)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        level_d = level_q;
        valid_d = valid_q;
        count_d = count_q;
        if (xfer_s) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
        if (accept_s) begin
            state_d = ST_SHIFT;
            idx_d   = '0;
            shreg_d = bus.in_data;
            level_d = next_level_s;
            valid_d = 1'b1;
        end else if ((state_q == ST_SHIFT) && xfer_s) begin
            if (last_s) begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                shreg_d = shifted_s;
                level_d = next_level_s;
            end
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            level_q <= level_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_level = level_q;
    assign bus.out_valid = valid_q;
    assign sym_count_o   = count_q;
endmodule

// File: tb/tb_pam4_tx_mapper.sv
// Directed self-checking bench for pam4_tx_mapper (default parameters, S=56).
module tb_pam4_tx_mapper;
    localparam int DW = 8;
    localparam int LW = 16;

    logic        clk;
    logic        rst;
    logic [31:0] sym_count;
    int          n_checks;
    int          n_pass;

    pam4_tx_mapper_if #(.DATA_WIDTH(DW), .LEVEL_W(LW)) bus ();

    pam4_tx_mapper #(
        .PULSE_RESPONSE_LENGTH (2),
        .SIGNAL_RESOLUTION     (8),
        .SYMBOL_SEPERATION     (56),
        .DATA_WIDTH            (DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus.slave),
        .sym_count_o (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PAM4_GRAY_EN
    // 0xB4, 0x00/0xFF pair, 0x1B
    localparam int EXP_B4 [4] = '{84, 28, -28, -84};
    localparam int EXP_FF     = 28;
    localparam int EXP_1B [4] = '{-84, -28, 84, 28};
`else
    localparam int EXP_B4 [4] = '{28, 84, -28, -84};
    localparam int EXP_FF     = 84;
    localparam int EXP_1B [4] = '{-84, -28, 28, 84};
`endif

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hB4;
        bus.out_ready = 1'b1;

        // 1: reset held with in_valid asserted
        repeat (3) tick();
        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_level", bus.out_level, 0);
        check_val("rst_ready", bus.in_ready, 0);
        check_val("rst_count", sym_count, 0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_val("idle_ready", bus.in_ready, 1);

        // 2: single word 0xB4, no backpressure
        bus.in_data  = 8'hB4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("b4_valid%0d", i), bus.out_valid, 1);
            check_val($sformatf("b4_level%0d", i), bus.out_level, EXP_B4[i]);
            tick();
        end
        check_val("b4_done", bus.out_valid, 0);
        check_val("b4_count", sym_count, 4);

        // 3: back-to-back 0x00 then 0xFF
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 8) bus.in_valid = 1'b0;
            #1;
            if (c < 8) check_val($sformatf("b2b_ready%0d", c), bus.in_ready, ((c == 0) || (c == 4)) ? 1 : 0);
            if (c >= 1) begin
                check_val($sformatf("b2b_valid%0d", c), bus.out_valid, 1);
                check_val($sformatf("b2b_level%0d", c), bus.out_level, (c <= 4) ? -84 : EXP_FF);
            end
            tick();
            bus.in_data = 8'hFF;
        end
        check_val("b2b_done", bus.out_valid, 0);
        check_val("b2b_count", sym_count, 12);

        // 4: backpressure on the first symbol
        bus.in_data  = 8'hB4;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("bp_level%0d", i), bus.out_level, EXP_B4[0]);
            check_val($sformatf("bp_valid%0d", i), bus.out_valid, 1);
            check_val($sformatf("bp_ready%0d", i), bus.in_ready, 0);
            check_val($sformatf("bp_count%0d", i), sym_count, 12);
        end
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_resume", bus.out_level, EXP_B4[1]);
        repeat (3) tick();
        check_val("bp_done", bus.out_valid, 0);
        check_val("bp_count", sym_count, 16);

        // 5: reset in the middle of a word
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (2) tick();
        check_val("mid_count", sym_count, 18);
        check_val("mid_level", bus.out_level, EXP_B4[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_valid", bus.out_valid, 0);
        check_val("mid_rst_count", sym_count, 0);
        bus.in_data  = 8'h1B;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("w1b_level%0d", i), bus.out_level, EXP_1B[i]);
            tick();
        end
        check_val("w1b_count", sym_count, 4);

        // 6: symbol counter wrap
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check_val("wrap_pre", sym_count, 32'hFFFF_FFFF);
        tick();
        check_val("wrap_post", sym_count, 0);
        repeat (3) tick();
        check_val("wrap_done", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
